// File: rtl/gb_sprite_pkg.sv
// Shared types and constants for the sprite pixel FIFO and its per-slot merge cell.
package gb_sprite_pkg;

  localparam int SPR_FIFO_DEPTH = 8;
  localparam int SPR_INDEX_W = 4;
  localparam logic [1:0] SPR_TRANSPARENT = 2'b00;

  typedef struct packed {
    logic [1:0]             color;
    logic                   pal;
    logic                   prio;
    logic [2:0]             cgb_pal;
    logic [SPR_INDEX_W-1:0] index;
  } spr_pix_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } fifo_state_e;

  function automatic logic spr_is_opaque(input logic [1:0] color);
    return (color != SPR_TRANSPARENT);
  endfunction

endpackage

// File: rtl/sprite_pixel_merge.sv
// One-slot sprite merge: decides whether an incoming pixel replaces the pixel already in a FIFO slot.
module sprite_pixel_merge
  import gb_sprite_pkg::*;
(
  input  spr_pix_t existing,
  input  spr_pix_t incoming,
  input  logic     cgb_mode,
  output spr_pix_t result
);

  // Transparent never wins; otherwise fill empty slots, and in CGB mode a lower OAM index wins.
  always_comb begin
    result = existing;
    if (!spr_is_opaque(incoming.color)) begin
      result = existing;
    end else if (!spr_is_opaque(existing.color)) begin
      result = incoming;
    end else if (cgb_mode && (incoming.index < existing.index)) begin
      result = incoming;
    end else begin
      result = existing;
    end
  end

endmodule

// File: rtl/sprite_pixel_fifo.sv
// Sprite pixel shift FIFO between the sprite stores and the BG/sprite mixer.
// Optional CGB attribute storage and merge rule enabled by defining SPRITE_FIFO_CGB_EN.
module sprite_pixel_fifo
  import gb_sprite_pkg::*;
#(
  parameter int DEPTH   = SPR_FIFO_DEPTH,
  parameter int INDEX_W = SPR_INDEX_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic               line_start,
  input  logic               line_end,
  input  logic               load,
  input  logic [7:0]         tile0_in,
  input  logic [7:0]         tile1_in,
  input  logic               pal_in,
  input  logic               prio_in,
  input  logic [2:0]         cgb_pal_in,
  input  logic [INDEX_W-1:0] index_in,
  input  logic               cgb_mode,
  input  logic               shift,
  output logic [1:0]         pix_color,
  output logic               pix_pal,
  output logic               pix_prio,
  output logic [2:0]         pix_cgb_pal,
  output logic [INDEX_W-1:0] pix_index,
  output logic               active
);

  fifo_state_e state_r;
  fifo_state_e state_next_s;
  logic        clear_s;
  logic        cgb_rule_s;
  spr_pix_t    slot_r      [DEPTH];
  spr_pix_t    shifted_s   [DEPTH];
  spr_pix_t    incoming_s  [DEPTH];
  spr_pix_t    merged_s    [DEPTH];
  spr_pix_t    slot_next_s [DEPTH];

`ifdef SPRITE_FIFO_CGB_EN
  assign cgb_rule_s = cgb_mode;
`else
  assign cgb_rule_s = 1'b0;
`endif

  // Line framing: line_start takes precedence, and either edge of the line empties the FIFO.
  always_comb begin
    state_next_s = state_r;
    clear_s      = 1'b0;
    if (line_start) begin
      state_next_s = ST_ACTIVE;
      clear_s      = 1'b1;
    end else if (line_end) begin
      state_next_s = ST_IDLE;
      clear_s      = 1'b1;
    end else begin
      state_next_s = state_r;
      clear_s      = 1'b0;
    end
  end

  // Post-shift view of the slots and the decoded incoming pixel row (bit7 = slot 0).
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      if (!shift) begin
        shifted_s[k] = slot_r[k];
      end else if (k < DEPTH - 1) begin
        shifted_s[k] = slot_r[(k + 1) % DEPTH];
      end else begin
        shifted_s[k] = '0;
      end
      incoming_s[k]       = '0;
      incoming_s[k].color = {tile1_in[DEPTH-1-k], tile0_in[DEPTH-1-k]};
      incoming_s[k].pal   = pal_in;
      incoming_s[k].prio  = prio_in;
`ifdef SPRITE_FIFO_CGB_EN
      incoming_s[k].cgb_pal = cgb_pal_in;
      incoming_s[k].index   = SPR_INDEX_W'(index_in);
`endif
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_merge
    sprite_pixel_merge u_merge (
      .existing (shifted_s[g]),
      .incoming (incoming_s[g]),
      .cgb_mode (cgb_rule_s),
      .result   (merged_s[g])
    );
  end

  // Merge only lands on a load; a bare shift just advances the row.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      if (load) begin
        slot_next_s[k] = merged_s[k];
      end else begin
        slot_next_s[k] = shifted_s[k];
      end
    end
  end

  // State and slot registers; everything except the async reset is gated by ce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      for (int k = 0; k < DEPTH; k++) slot_r[k] <= '0;
    end else if (ce) begin
      state_r <= state_next_s;
      if (clear_s) begin
        for (int k = 0; k < DEPTH; k++) slot_r[k] <= '0;
      end else if (state_r == ST_ACTIVE) begin
        for (int k = 0; k < DEPTH; k++) slot_r[k] <= slot_next_s[k];
      end else begin
        for (int k = 0; k < DEPTH; k++) slot_r[k] <= slot_r[k];
      end
    end else begin
      state_r <= state_r;
    end
  end

  assign pix_color = slot_r[0].color;
  assign pix_pal   = slot_r[0].pal;
  assign pix_prio  = slot_r[0].prio;
  assign active    = (state_r == ST_ACTIVE);

`ifdef SPRITE_FIFO_CGB_EN
  assign pix_cgb_pal = slot_r[0].cgb_pal;
  assign pix_index   = INDEX_W'(slot_r[0].index);
`else
  logic unused_cgb_s;
  assign unused_cgb_s = ^{cgb_pal_in, index_in, cgb_mode, slot_r[0].cgb_pal, slot_r[0].index};
  assign pix_cgb_pal  = 3'b000;
  assign pix_index    = '0;
`endif

endmodule

// File: tb/tb_sprite_pixel_fifo.sv
// Self-checking bench for sprite_pixel_fifo: queue-style reference model plus directed literal checks.
module tb_sprite_pixel_fifo;

`ifdef SPRITE_FIFO_CGB_EN
  localparam bit CGB_EN = 1'b1;
`else
  localparam bit CGB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       ce = 1'b1;
  logic       line_start = 1'b0;
  logic       line_end = 1'b0;
  logic       load = 1'b0;
  logic [7:0] tile0_in = 8'h00;
  logic [7:0] tile1_in = 8'h00;
  logic       pal_in = 1'b0;
  logic       prio_in = 1'b0;
  logic [2:0] cgb_pal_in = 3'd0;
  logic [3:0] index_in = 4'd0;
  logic       cgb_mode = 1'b0;
  logic       shift = 1'b0;
  logic [1:0] pix_color;
  logic       pix_pal;
  logic       pix_prio;
  logic [2:0] pix_cgb_pal;
  logic [3:0] pix_index;
  logic       active;

  int n_checks = 0;
  int n_fail = 0;

  sprite_pixel_fifo dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .line_start(line_start), .line_end(line_end),
    .load(load), .tile0_in(tile0_in), .tile1_in(tile1_in), .pal_in(pal_in), .prio_in(prio_in),
    .cgb_pal_in(cgb_pal_in), .index_in(index_in), .cgb_mode(cgb_mode), .shift(shift),
    .pix_color(pix_color), .pix_pal(pix_pal), .pix_prio(pix_prio), .pix_cgb_pal(pix_cgb_pal),
    .pix_index(pix_index), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] color;
    logic       pal;
    logic       prio;
    logic [2:0] cgb;
    logic [3:0] idx;
  } mpx_t;
  typedef mpx_t mline_t [8];

  mline_t m_px;
  logic   m_active;

  function automatic mline_t blank_line();
    mline_t r;
    for (int i = 0; i < 8; i++) r[i] = '0;
    return r;
  endfunction

  // Reference: the row behaves like a queue; pop the front on shift, then overlay the new sprite row.
  function automatic mline_t model_next(input mline_t cur, input logic do_shift, input logic do_load);
    mline_t r;
    mpx_t   n;
    int     c;
    r = cur;
    if (do_shift) begin
      for (int i = 0; i < 7; i++) r[i] = cur[i + 1];
      r[7] = '0;
    end
    if (do_load) begin
      for (int k = 0; k < 8; k++) begin
        c = 2 * int'(tile1_in[7 - k]) + int'(tile0_in[7 - k]);
        n = '0;
        n.color = c[1:0];
        n.pal = pal_in;
        n.prio = prio_in;
        if (CGB_EN) begin
          n.cgb = cgb_pal_in;
          n.idx = index_in;
        end
        if (c != 0 && (r[k].color == 2'd0 ||
                       (CGB_EN && cgb_mode && index_in < r[k].idx))) begin
          r[k] = n;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_px <= blank_line();
    end else if (ce) begin
      if (line_start) begin
        m_active <= 1'b1;
        m_px <= blank_line();
      end else if (line_end) begin
        m_active <= 1'b0;
        m_px <= blank_line();
      end else if (m_active) begin
        m_px <= model_next(m_px, shift, load);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("mdl_active", int'(active), int'(m_active));
    chk("mdl_color", int'(pix_color), int'(m_px[0].color));
    chk("mdl_pal", int'(pix_pal), int'(m_px[0].pal));
    chk("mdl_prio", int'(pix_prio), int'(m_px[0].prio));
    chk("mdl_cgb_pal", int'(pix_cgb_pal), int'(m_px[0].cgb));
    chk("mdl_index", int'(pix_index), int'(m_px[0].idx));
  end

  task automatic cyc(input logic ls, input logic le, input logic ld, input logic sh,
                     input logic [7:0] t0, input logic [7:0] t1, input logic pl,
                     input logic [3:0] idx);
    line_start = ls;
    line_end = le;
    load = ld;
    shift = sh;
    tile0_in = t0;
    tile1_in = t1;
    pal_in = pl;
    prio_in = ~pl;
    index_in = idx;
    cgb_pal_in = idx[2:0];
    @(negedge clk);
    line_start = 1'b0;
    line_end = 1'b0;
    load = 1'b0;
    shift = 1'b0;
  endtask

  initial begin
    int exp2 [8];
    exp2 = '{3, 3, 3, 3, 2, 2, 2, 2};
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_active", int'(active), 0);
    chk("rst_color", int'(pix_color), 0);
    reset_n = 1'b1;

    // single load, pixels drain in order
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    chk("t2_active", int'(active), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 8'hFF, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_color%0d", i), int'(pix_color), exp2[i]);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'd0);
    end
    chk("t2_drained", int'(pix_color), 0);

    // DMG overlap, first loaded wins
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 4'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_color%0d", i), int'(pix_color), (i < 6) ? 1 : 2);
      chk($sformatf("t3_pal%0d", i), int'(pix_pal), (i < 6) ? 0 : 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'd0);
    end

    // CGB index priority, then DMG rule on the same stimulus
    cgb_mode = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 4'd5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 4'd2);
    chk("t4_cgb_color", int'(pix_color), CGB_EN ? 2 : 1);
    chk("t4_cgb_index", int'(pix_index), CGB_EN ? 2 : 0);
    repeat (7) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'd0);
    chk("t4_cgb_color7", int'(pix_color), CGB_EN ? 2 : 1);
    cgb_mode = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 4'd5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 4'd2);
    chk("t4_dmg_color", int'(pix_color), 1);
    chk("t4_dmg_index", int'(pix_index), CGB_EN ? 5 : 0);

    // shift and load in the same cycle
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 8'h00, 1'b1, 4'd0);
    chk("t5_opaque_color", int'(pix_color), 3);
    chk("t5_opaque_pal", int'(pix_pal), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 8'h00, 1'b1, 4'd0);
    chk("t5_new_color", int'(pix_color), 1);
    chk("t5_new_pal", int'(pix_pal), 1);

    // ce gating and IDLE behaviour
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 4'd0);
    ce = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b0, 4'd0);
    chk("t6_hold_color", int'(pix_color), 3);
    chk("t6_hold_pal", int'(pix_pal), 1);
    chk("t6_hold_active", int'(active), 1);
    ce = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    chk("t6_end_active", int'(active), 0);
    chk("t6_end_color", int'(pix_color), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 4'd0);
    chk("t6_idle_load", int'(pix_color), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 4'd0);
    chk("t6_idle_pal", int'(pix_pal), 0);

    // asynchronous reset mid-line
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 4'd3);
    chk("t1_pre_color", int'(pix_color), 3);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async_color", int'(pix_color), 0);
    chk("t1_async_pal", int'(pix_pal), 0);
    chk("t1_async_active", int'(active), 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 4'd0);
    chk("t1_post_active", int'(active), 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
